reg_dump_reader: RTL

Sequential read-out engine for the 32-entry integer register file. On a start pulse it walks register addresses 0..2^ADDRESS_WIDTH-1 through one combinational read port, captures each value, and streams it out on a valid/ready interface toward the debug/trace path. It is the reader counterpart to the core's write-back path: it only drives read addresses and never writes the register file.

---
 rtl/reg_dump_if.sv | 28 ++
 rtl/reg_dump_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_dump_if.sv
// reg_dump_if: output word stream of the register-file dump reader.
//
// Handshake: a word transfers on a rising clk edge where m_valid and m_ready
// are both high. Once m_valid rises, m_valid, m_data, m_addr and m_last hold
// steady until that transfer; m_ready may change at any time and has no
// combinational path back to m_valid.
//
// Signals:
//   m_valid  master -> slave  word valid
//   m_ready  slave  -> master consumer accepts the word
//   m_data   master -> slave  register value (or checksum word)
//   m_addr   master -> slave  register index of m_data (0 for the checksum)
//   m_last   master -> slave  final word of the dump
interface reg_dump_if #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     m_valid;
  logic                     m_ready;
  logic [D_WIDTH-1:0]       m_data;
  logic [ADDRESS_WIDTH-1:0] m_addr;
  logic                     m_last;

  modport master (output m_valid, output m_data, output m_addr, output m_last,
                  input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_addr, input  m_last,
                  output m_ready);
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: on a start pulse, walk register addresses
// 0..2**ADDRESS_WIDTH-1 through a combinational read port and stream each
// value out as one word. The block only drives read addresses and never
// writes the register file.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append one extra word
// holding the XOR of every dumped register (m_addr=0, m_last=1).
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   start      begin a dump; only looked at while idle
//   busy       dump in progress (low while idle and during the done pulse)
//   done       one-cycle pulse after the final word transfers
//   rd_addr    register-file read address
//   rd_data    register-file read data (combinational from rd_addr)
//   m          output word stream (reg_dump_if master)
//   dbg_state  current FSM state encoding
module reg_dump_reader #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0]       rd_data,
  reg_dump_if.master               m,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = '1;

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   idx;
  logic [D_WIDTH-1:0]         data_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic                       valid_q;
  logic                       last_q;
  logic                       busy_q;
  logic                       done_q;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [D_WIDTH-1:0]         csum;
`endif

  // idx is zero whenever the FSM is idle, so the read address can come
  // straight from it in every state.
  assign rd_addr   = idx;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_addr  = addr_q;
  assign m.m_last  = last_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= READ;
            busy_q <= 1'b1;
          end
        end

        READ: begin
          // The value visible on rd_data at this edge is the snapshot for idx.
          data_q  <= rd_data;
          addr_q  <= idx;
          valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          last_q  <= 1'b0;
`else
          last_q  <= (idx == LAST_IDX);
`endif
          state   <= SEND;
        end

        SEND: begin
          if (m.m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum    <= csum ^ data_q;
`endif
            // Compare before incrementing so idx never wraps inside a dump.
            if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              state   <= CSUM;
              data_q  <= csum ^ data_q;
              addr_q  <= '0;
              valid_q <= 1'b1;
              last_q  <= 1'b1;
`else
              state   <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (m.m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif

        DONE: begin
          done_q <= 1'b0;
          idx    <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum   <= '0;
`endif
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
